ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits.
REQ-002 Parameter ADDR_W, default 30, byte-address width.
REQ-003 Parameter BE_W, default 4, byte-enable width (DATA_W/8).
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 i_req  in  1  instruction-port read request, held until i_ack.
REQ-007 i_addr  in  ADDR_W  instruction byte address.
REQ-008 i_ack  out  1  one-cycle pulse: instruction transaction complete.
REQ-009 i_rdata  out  DATA_W  instruction read data, valid with i_ack, held until next i_ack.
REQ-010 d_req  in  1  data-port request, held until d_ack.
REQ-011 d_we  in  BE_W  byte write enables; all-zero means read.
REQ-012 d_addr  in  ADDR_W  data byte address.
REQ-013 d_wdata  in  DATA_W  write data.
REQ-014 d_ack  out  1  one-cycle pulse: data transaction complete.
REQ-015 d_rdata  out  DATA_W  data read data, valid with d_ack, held until next read d_ack.
REQ-016 ram_cs/ram_we/ram_addr/ram_wdata  out  1/BE_W/ADDR_W/DATA_W  registered RAM control.
REQ-017 ram_rdata  in  DATA_W  RAM read data, valid one cycle after the cs cycle.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP; IDLE->ACCESS on any eligible request, ACCESS->RESP, RESP->IDLE unconditionally.
REQ-019 In IDLE with a grant, the granted port's addr/we/wdata SHALL be registered onto ram_*, with ram_cs=1 for exactly the ACCESS cycle; ram_cs=0 and ram_we=0 in all other states.
REQ-020 Instruction grants SHALL drive ram_we=0 and ram_wdata=0.
REQ-021 In RESP, for a read, ram_rdata SHALL be registered into the granted port's rdata; the granted port's ack SHALL be registered high, visible in the following cycle.
REQ-022 Latency: ack SHALL assert exactly 3 cycles after the IDLE cycle in which req was sampled; throughput one transaction per 3 cycles.
REQ-023 Writes SHALL ack identically; d_rdata SHALL remain unchanged on write acks.
REQ-024 A port's req SHALL be ignored during the cycle its own ack is high (stale-request guard); a back-to-back transaction from that port starts at the next IDLE cycle.
REQ-025 When both ports are eligible in IDLE, arbitration SHALL be round-robin: grant the port not granted last; a lone requester is always granted.
REQ-026 Addresses SHALL pass to the RAM unmodified; no alignment check.
REQ-027 Requester changes to addr/we/wdata after the grant cycle SHALL NOT affect the in-flight transaction.
REQ-028 At most one ack SHALL be high in any cycle.

Reset
REQ-029 rst SHALL force state IDLE, ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, last-grant=instruction (data wins first contention).
REQ-030 rst asserted mid-transaction SHALL abandon it without ack; the RAM write already issued in ACCESS is not undone.

Structure
REQ-031 Shared package ram_arb_pkg SHALL hold state encoding and default width constants (32/30/4).
REQ-032 The two-way round-robin picker SHALL be sub-module rr_arb2 (inputs req[1:0], last; output gnt[1:0]).

Verification
REQ-033 i_req only, i_addr=0x100, RAM word 0x11223344 -> ram_cs one cycle with addr 0x100, i_ack 3 cycles later, i_rdata=0x11223344.
REQ-034 d_req write d_we=4'b0101, d_addr=0x200, d_wdata=0xAABBCCDD -> ram_we=0101 during ACCESS, d_ack pulse, d_rdata unchanged.
REQ-035 i_req and d_req both held high from reset -> grant order D, I, D, I; no ack overlaps; each ack 3 cycles apart.
REQ-036 d_req held high through d_ack for two reads (0x10, 0x14) -> exactly two ram_cs pulses, no duplicate from stale req.
REQ-037 rst pulsed during ACCESS of an i_req read -> no i_ack, all outputs 0, FSM IDLE; next request served normally.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants and state encoding for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 30;
  localparam int DEF_BE_W   = 4;

  // Requester indices into the request/grant vectors.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the arbiter.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BE_W   = DEF_BE_W
);

  // Instruction port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  // Data port
  logic              d_req;
  logic [BE_W-1:0]   d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  // RAM side
  logic              ram_cs;
  logic [BE_W-1:0]   ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter view
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, ram_cs, ram_we, ram_addr, ram_wdata
  );

  // Requesters plus RAM view
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, ram_cs, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, on contention
// the port that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Combinational grant selection
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous RAM between an instruction and a data requester.
// Each transaction walks IDLE -> ACCESS -> RESP, giving an ack three cycles
// after the request is sampled in IDLE.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BE_W   = DEF_BE_W
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  state_t            state_q;
  logic              last_q;
  logic              gnt_d_q;
  logic              rd_q;
  logic              ram_cs_q;
  logic [BE_W-1:0]   ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              i_ack_q;
  logic              d_ack_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic [1:0]        elig;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_we;
  logic [DATA_W-1:0] sel_wdata;

  // A request seen while its own ack is high is the stale tail of the
  // transaction just completed, so it is masked for that cycle.
  assign elig[PORT_I] = bus.i_req & ~i_ack_q;
  assign elig[PORT_D] = bus.d_req & ~d_ack_q;

  rr_arb2 u_rr (
    .req  (elig),
    .last (last_q),
    .gnt  (gnt)
  );

  // Select the granted port's command; instruction side is always a read
  always_comb begin
    sel_addr  = bus.i_addr;
    sel_we    = '0;
    sel_wdata = '0;
    if (gnt[PORT_D]) begin
      sel_addr  = bus.d_addr;
      sel_we    = bus.d_we;
      sel_wdata = bus.d_wdata;
    end
  end

  // Transaction FSM with registered RAM control, acks and read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= PORT_I;
      gnt_d_q     <= 1'b0;
      rd_q        <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            state_q     <= ST_ACCESS;
            ram_cs_q    <= 1'b1;
            ram_we_q    <= sel_we;
            ram_addr_q  <= sel_addr;
            ram_wdata_q <= sel_wdata;
            gnt_d_q     <= gnt[PORT_D];
            last_q      <= gnt[PORT_D];
            rd_q        <= (sel_we == '0);
          end
        end
        ST_ACCESS: begin
          state_q  <= ST_RESP;
          ram_cs_q <= 1'b0;
          ram_we_q <= '0;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          if (gnt_d_q) begin
            d_ack_q <= 1'b1;
            if (rd_q) d_rdata_q <= bus.ram_rdata;
          end else begin
            i_ack_q   <= 1'b1;
            i_rdata_q <= bus.ram_rdata;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_cs    = ram_cs_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed stimulus pushes expected RAM
// accesses and acks, a negedge monitor pops and compares them.
module tb_ram_arbiter;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   cs_count = 0;
  int   cs_cyc = -100;

  acc_t accq[$];
  ack_t ackq[$];
  logic [31:0] mem [256];

  ram_arbiter_if #(.DATA_W(32), .ADDR_W(30), .BE_W(4)) bus ();

  ram_arbiter #(.DATA_W(32), .ADDR_W(30), .BE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void exp_acc(input logic [29:0] a, input logic [3:0] we, input logic [31:0] wd);
    acc_t e;
    e.addr = a; e.we = we; e.wdata = wd;
    accq.push_back(e);
  endfunction

  function automatic void exp_ack(input bit is_d, input logic [31:0] rd);
    ack_t e;
    e.is_d = is_d; e.rdata = rd;
    ackq.push_back(e);
  endfunction

  // Synchronous RAM model: read data one cycle after the cs cycle
  initial begin
    logic [7:0] a;
    for (int k = 0; k < 256; k++) mem[k] = '0;
    mem[8'h40] = 32'h1122_3344;  // 0x100
    mem[8'h04] = 32'hCAFE_0010;  // 0x10
    mem[8'h05] = 32'hCAFE_0014;  // 0x14
    bus.ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.ram_cs) begin
        a = bus.ram_addr[9:2];
        bus.ram_rdata <= mem[a];
        for (int b = 0; b < 4; b++)
          if (bus.ram_we[b]) mem[a][8*b +: 8] = bus.ram_wdata[8*b +: 8];
      end
    end
  end

  // Monitor: compares every RAM access and every ack against the queues
  initial begin
    acc_t ea;
    ack_t ek;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("single_ack", {31'd0, bus.i_ack & bus.d_ack}, 32'd0);
        if (bus.ram_cs) begin
          cs_count++;
          cs_cyc = cyc;
          if (accq.size() == 0) begin
            chk("unexpected_ram_cs", 32'd1, 32'd0);
          end else begin
            ea = accq.pop_front();
            chk("ram_addr", {2'b00, bus.ram_addr}, {2'b00, ea.addr});
            chk("ram_we", {28'd0, bus.ram_we}, {28'd0, ea.we});
            chk("ram_wdata", bus.ram_wdata, ea.wdata);
          end
        end else begin
          chk("ram_we_idle", {28'd0, bus.ram_we}, 32'd0);
        end
        if (bus.i_ack || bus.d_ack) begin
          chk("cs_to_ack", cyc - cs_cyc, 32'd2);
          if (ackq.size() == 0) begin
            chk("unexpected_ack", 32'd1, 32'd0);
          end else begin
            ek = ackq.pop_front();
            chk("ack_port", {31'd0, bus.d_ack}, {31'd0, ek.is_d});
            if (ek.is_d) chk("d_rdata", bus.d_rdata, ek.rdata);
            else         chk("i_rdata", bus.i_rdata, ek.rdata);
          end
        end
      end
    end
  end

  task automatic wait_ack(input bit is_d, output int at);
    at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (is_d ? bus.d_ack : bus.i_ack) begin
        at = cyc;
        return;
      end
    end
    chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_any(output bit is_d, output int at);
    at = -1;
    is_d = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) begin
        is_d = bus.d_ack;
        at = cyc;
        return;
      end
    end
    chk("any_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_i_ack"},     {31'd0, bus.i_ack}, 32'd0);
    chk({tag, "_d_ack"},     {31'd0, bus.d_ack}, 32'd0);
    chk({tag, "_ram_cs"},    {31'd0, bus.ram_cs}, 32'd0);
    chk({tag, "_ram_we"},    {28'd0, bus.ram_we}, 32'd0);
    chk({tag, "_ram_addr"},  {2'b00, bus.ram_addr}, 32'd0);
    chk({tag, "_ram_wdata"}, bus.ram_wdata, 32'd0);
    chk({tag, "_i_rdata"},   bus.i_rdata, 32'd0);
    chk({tag, "_d_rdata"},   bus.d_rdata, 32'd0);
  endtask

  // Directed stimulus
  initial begin
    int at;
    int prev;
    int c0;
    int cs0;
    bit is_d;
    bit ord [4];
    ord = '{1'b1, 1'b0, 1'b1, 1'b0};

    // Both ports requesting straight out of reset: D, I, D, I
    bus.i_req = 1'b1; bus.i_addr = 30'h100;
    bus.d_req = 1'b1; bus.d_addr = 30'h10; bus.d_we = '0; bus.d_wdata = '0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    for (int k = 0; k < 2; k++) begin
      exp_acc(30'h10, 4'h0, 32'h0);  exp_ack(1'b1, 32'hCAFE_0010);
      exp_acc(30'h100, 4'h0, 32'h0); exp_ack(1'b0, 32'h1122_3344);
    end
    rst = 1'b0;
    prev = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_any(is_d, at);
      chk("rr_order", {31'd0, is_d}, {31'd0, ord[k]});
      chk("ack_spacing", at - prev, 32'd3);
      prev = at;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (4) @(negedge clk);

    // Lone instruction read, latency from sampling IDLE cycle
    cs0 = cs_count;
    exp_acc(30'h100, 4'h0, 32'h0);
    exp_ack(1'b0, 32'h1122_3344);
    bus.i_addr = 30'h100; bus.i_req = 1'b1;
    c0 = cyc;
    wait_ack(1'b0, at);
    bus.i_req = 1'b0;
    chk("i_latency", at - c0, 32'd3);
    repeat (3) @(negedge clk);
    chk("i_cs_pulses", cs_count - cs0, 32'd1);

    // Data reads with req held through the first ack
    cs0 = cs_count;
    exp_acc(30'h10, 4'h0, 32'h0); exp_ack(1'b1, 32'hCAFE_0010);
    exp_acc(30'h14, 4'h0, 32'h0); exp_ack(1'b1, 32'hCAFE_0014);
    bus.d_we = '0; bus.d_addr = 30'h10; bus.d_req = 1'b1;
    wait_ack(1'b1, at);
    bus.d_addr = 30'h14;
    wait_ack(1'b1, at);
    bus.d_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_req_cs_pulses", cs_count - cs0, 32'd2);

    // Byte-masked write; requester changes command mid-flight
    exp_acc(30'h200, 4'b0101, 32'hAABB_CCDD);
    exp_ack(1'b1, 32'hCAFE_0014);
    bus.d_we = 4'b0101; bus.d_addr = 30'h200; bus.d_wdata = 32'hAABB_CCDD; bus.d_req = 1'b1;
    @(negedge clk);
    bus.d_we = 4'b1111; bus.d_addr = 30'h300; bus.d_wdata = 32'h0;
    wait_ack(1'b1, at);
    bus.d_req = 1'b0; bus.d_we = '0;
    chk("i_rdata_held", bus.i_rdata, 32'h1122_3344);
    repeat (2) @(negedge clk);

    // Read back the partially written word
    exp_acc(30'h200, 4'h0, 32'h0);
    exp_ack(1'b1, 32'h00BB_00DD);
    bus.d_addr = 30'h200; bus.d_req = 1'b1;
    wait_ack(1'b1, at);
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during ACCESS abandons the instruction read
    exp_acc(30'h100, 4'h0, 32'h0);
    bus.i_addr = 30'h100; bus.i_req = 1'b1;
    at = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.ram_cs) begin
        at = cyc;
        break;
      end
    end
    chk("abort_cs_seen", {31'd0, at >= 0}, 32'd1);
    #2;
    rst = 1'b1;
    bus.i_req = 1'b0;
    @(negedge clk);
    chk_zero_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Normal service after the abort
    exp_acc(30'h10, 4'h0, 32'h0);
    exp_ack(1'b0, 32'hCAFE_0010);
    bus.i_addr = 30'h10; bus.i_req = 1'b1;
    c0 = cyc;
    wait_ack(1'b0, at);
    bus.i_req = 1'b0;
    chk("post_reset_latency", at - c0, 32'd3);
    repeat (3) @(negedge clk);

    chk("acc_queue_drained", accq.size(), 32'd0);
    chk("ack_queue_drained", ackq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
